alu_share_arbiter: RTL and testbench

- Shares one instance of the team's 32-bit `alu` between two requesters, port 0 and port 1.
- Each requester presents opcode, shift amount and operands over a valid/ready handshake.
- Arbitration is round-robin. The block latches the winning request and returns the registered result with flags and the requester ID over a valid/ready response channel.
- Sits between the decode/issue stages and the ALU datapath, including its 32-bit OR-reduction zero detect.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 47 ++++
 rtl/or_reduce.sv | 11 +
 rtl/rr_arb2.sv | 25 ++
 rtl/alu_share_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, default widths and arbiter state type
package alu_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_OPW     = 5;
  localparam int DEF_NUM_OPS = 6;

  localparam logic [DEF_OPW-1:0] OP_ADD = 5'd0;
  localparam logic [DEF_OPW-1:0] OP_SUB = 5'd1;
  localparam logic [DEF_OPW-1:0] OP_AND = 5'd2;
  localparam logic [DEF_OPW-1:0] OP_OR  = 5'd3;
  localparam logic [DEF_OPW-1:0] OP_SLL = 5'd4;
  localparam logic [DEF_OPW-1:0] OP_SRA = 5'd5;

  // IDLE: response register empty; HOLD: response register full
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with compare and overflow flags
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [OPW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ne,
  output logic             lt,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Operation select; overflow is signed overflow for add/sub only
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

  assign ne = (a != b);
  assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/or_reduce.sv
// rtl/or_reduce.sv - OR-reduction used for zero detect
module or_reduce #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  output logic             any
);

  assign any = |d;

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant pointer
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant
);

  logic last;

  // Remember the last winner; reset value 1 lets port 0 win the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last <= 1'b1;
    else if (take) last <= grant;
  end

  // On a tie the port that did not win last time goes next
  always_comb begin
    grant = 1'b0;
    if (req[0] && req[1]) grant = ~last;
    else                  grant = req[1];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OPW     = DEF_OPW,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req0_shamt,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [OPW-1:0]   req1_shamt,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ne,
  output logic             resp_lt,
  output logic             resp_ovf,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);

  localparam logic [OPW:0] OP_LIMIT = (OPW+1)'(NUM_OPS);

  arb_state_t state;
  arb_state_t state_nxt;

  logic             hold_valid;
  logic             hold_adv;
  logic             can_accept;
  logic             accept;
  logic             grant;

  logic             ex_valid;
  logic             ex_id;
  logic             ex_err;
  logic [OPW-1:0]   ex_op;
  logic [OPW-1:0]   ex_shamt;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;

  logic [OPW-1:0]   sel_op;
  logic [OPW-1:0]   sel_shamt;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_illegal;

  logic [OPW-1:0]   alu_op;
  logic [OPW-1:0]   alu_shamt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ne;
  logic             alu_lt;
  logic             alu_ovf;
  logic             res_any;

  // HOLD moves when empty or being popped; EXEC may fill whenever it can move on
  assign hold_adv   = !hold_valid || resp_ready;
  assign can_accept = !ex_valid || hold_adv;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .take  (accept),
    .grant (grant)
  );

  // Ready only for the granted port and only while it is actually requesting
  assign req0_ready = can_accept && req0_valid && !grant && !reset;
  assign req1_ready = can_accept && req1_valid &&  grant && !reset;
  assign accept     = req0_ready || req1_ready;

  assign sel_op      = grant ? req1_op    : req0_op;
  assign sel_shamt   = grant ? req1_shamt : req0_shamt;
  assign sel_a       = grant ? req1_a     : req0_a;
  assign sel_b       = grant ? req1_b     : req0_b;
  assign sel_illegal = ({1'b0, sel_op} >= OP_LIMIT);

  // EXEC stage: latch the winning request; empties when it advances into HOLD
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_id    <= 1'b0;
      ex_err   <= 1'b0;
      ex_op    <= '0;
      ex_shamt <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_id    <= grant;
      ex_err   <= sel_illegal;
      ex_op    <= sel_op;
      ex_shamt <= sel_shamt;
      ex_a     <= sel_a;
      ex_b     <= sel_b;
    end else if (hold_adv) begin
      ex_valid <= 1'b0;
    end
  end

  // Illegal opcodes never reach the ALU: add of zeros yields zero result and flags
  assign alu_op    = ex_err ? OP_ADD : ex_op;
  assign alu_shamt = ex_err ? '0     : ex_shamt;
  assign alu_a     = ex_err ? '0     : ex_a;
  assign alu_b     = ex_err ? '0     : ex_b;

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op     (alu_op),
    .shamt  (alu_shamt),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .ne     (alu_ne),
    .lt     (alu_lt),
    .ovf    (alu_ovf)
  );

  // Response register: captures the ALU output as EXEC advances into HOLD
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_ne     <= 1'b0;
      resp_lt     <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
    end else if (hold_adv && ex_valid) begin
      resp_id     <= ex_id;
      resp_result <= alu_result;
      resp_ne     <= alu_ne;
      resp_lt     <= alu_lt;
      resp_ovf    <= alu_ovf;
      resp_err    <= ex_err;
    end
  end

  or_reduce #(.WIDTH(WIDTH)) u_zero (
    .d   (resp_result),
    .any (res_any)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: fill from EXEC, drain to IDLE only when popped with nothing behind
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ex_valid) state_nxt = ST_HOLD;
      ST_HOLD: if (resp_ready && !ex_valid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; zero flag is suppressed for errors and when empty
  always_comb begin
    hold_valid = (state == ST_HOLD);
    resp_valid = hold_valid;
    resp_zero  = hold_valid && !resp_err && !res_any;
    busy       = ex_valid || hold_valid;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_op, req0_shamt;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_op, req1_shamt;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_ne, resp_lt, resp_ovf, resp_zero, resp_err, busy;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_shamt  (req0_shamt),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_shamt  (req1_shamt),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_ne     (resp_ne),
    .resp_lt     (resp_lt),
    .resp_ovf    (resp_ovf),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_shamt = sh; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_shamt = sh; req1_a = a; req1_b = b;
  endtask

  initial begin
    reset = 1'b1;
    resp_ready = 1'b0;
    set0(1'b1, OP_ADD, 5'd0, 32'd5, 32'd7);
    set1(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);

    // 1: reset state, then a lone add on port 0
    #12;
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_req0_ready", req0_ready, 1'b0);
    chk ("rst_result", resp_result, 32'h0);
    chkb("rst_zero", resp_zero, 1'b0);
    reset = 1'b0;
    #1;
    chkb("t1_req0_ready", req0_ready, 1'b1);
    chkb("t1_req1_ready", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    chkb("t1_busy", busy, 1'b1);
    chkb("t1_valid_early", resp_valid, 1'b0);
    step();
    #1;
    chkb("t1_valid", resp_valid, 1'b1);
    chkb("t1_id", resp_id, 1'b0);
    chk ("t1_result", resp_result, 32'd12);
    chkb("t1_zero", resp_zero, 1'b0);
    chkb("t1_ne", resp_ne, 1'b1);
    chkb("t1_lt", resp_lt, 1'b1);
    chkb("t1_ovf", resp_ovf, 1'b0);
    chkb("t1_err", resp_err, 1'b0);
    resp_ready = 1'b1;
    step();
    #1;
    chkb("t1_drained", resp_valid, 1'b0);
    chkb("t1_idle_busy", busy, 1'b0);

    // 2: both ports every cycle; last grant was 0 so port 1 wins first
    set0(1'b0, OP_SUB, 5'd0, 32'd3, 32'd3);
    set1(1'b0, OP_OR, 5'd0, 32'hF0, 32'h0F);
    for (int i = 0; i < 6; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      #1;
      if (i < 4) begin
        chkb("t2_req1_ready", req1_ready, (i % 2 == 0));
        chkb("t2_req0_ready", req0_ready, (i % 2 != 0));
      end
      if (i >= 2) begin
        chkb("t2_valid", resp_valid, 1'b1);
        chkb("t2_id", resp_id, (i % 2 == 0));
        chk ("t2_result", resp_result, (i % 2 == 0) ? 32'hFF : 32'h0);
        chkb("t2_zero", resp_zero, (i % 2 != 0));
        chkb("t2_ne", resp_ne, (i % 2 == 0));
      end
      step();
    end
    #1;
    chkb("t2_end_valid", resp_valid, 1'b0);
    chkb("t2_end_busy", busy, 1'b0);

    // 3: consumer stalls with one response held and one in EXEC
    resp_ready = 1'b0;
    set0(1'b1, OP_ADD, 5'd0, 32'd1, 32'd2);
    #1;
    chkb("t3_acc0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    set1(1'b1, OP_OR, 5'd0, 32'h10, 32'h01);
    #1;
    chkb("t3_acc1", req1_ready, 1'b1);
    chkb("t3_valid_early", resp_valid, 1'b0);
    step();
    set0(1'b1, OP_ADD, 5'd0, 32'd4, 32'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chkb("t3_stall_valid", resp_valid, 1'b1);
      chk ("t3_stall_result", resp_result, 32'd3);
      chkb("t3_stall_id", resp_id, 1'b0);
      chkb("t3_stall_ready0", req0_ready, 1'b0);
      chkb("t3_stall_ready1", req1_ready, 1'b0);
      chkb("t3_stall_busy", busy, 1'b1);
      step();
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    chkb("t3_rel_ready0", req0_ready, 1'b1);
    chk ("t3_rel_result", resp_result, 32'd3);
    step();
    req0_valid = 1'b0;
    #1;
    chkb("t3_d1_valid", resp_valid, 1'b1);
    chkb("t3_d1_id", resp_id, 1'b1);
    chk ("t3_d1_result", resp_result, 32'h11);
    step();
    #1;
    chkb("t3_d2_valid", resp_valid, 1'b1);
    chkb("t3_d2_id", resp_id, 1'b0);
    chk ("t3_d2_result", resp_result, 32'd8);
    step();
    #1;
    chkb("t3_end_valid", resp_valid, 1'b0);

    // 4: overflow, compare and shifts back to back on port 0
    set0(1'b1, OP_ADD, 5'd0, 32'h7FFFFFFF, 32'd1);
    #1;
    chkb("t4_ready", req0_ready, 1'b1);
    step();
    set0(1'b1, OP_SUB, 5'd0, 32'd2, 32'd5);
    step();
    set0(1'b1, OP_SLL, 5'd4, 32'd1, 32'd0);
    #1;
    chk ("t4_add_result", resp_result, 32'h80000000);
    chkb("t4_add_ovf", resp_ovf, 1'b1);
    chkb("t4_add_zero", resp_zero, 1'b0);
    step();
    set0(1'b1, OP_SRA, 5'd4, 32'h80000000, 32'd0);
    #1;
    chk ("t4_sub_result", resp_result, 32'hFFFFFFFD);
    chkb("t4_sub_lt", resp_lt, 1'b1);
    chkb("t4_sub_ne", resp_ne, 1'b1);
    chkb("t4_sub_ovf", resp_ovf, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    chk ("t4_sll_result", resp_result, 32'h10);
    step();
    #1;
    chk ("t4_sra_result", resp_result, 32'hF8000000);
    step();
    #1;
    chkb("t4_end_valid", resp_valid, 1'b0);

    // 5: illegal opcode on port 1, then arbitration carries on
    set1(1'b1, 5'd7, 5'd3, 32'h1234, 32'h5678);
    #1;
    chkb("t5_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    #1;
    chkb("t5_valid", resp_valid, 1'b1);
    chkb("t5_id", resp_id, 1'b1);
    chkb("t5_err", resp_err, 1'b1);
    chk ("t5_result", resp_result, 32'h0);
    chkb("t5_ne", resp_ne, 1'b0);
    chkb("t5_lt", resp_lt, 1'b0);
    chkb("t5_ovf", resp_ovf, 1'b0);
    chkb("t5_zero", resp_zero, 1'b0);
    set0(1'b1, OP_AND, 5'd0, 32'hFF, 32'h0F);
    set1(1'b1, OP_OR, 5'd0, 32'hF0, 32'h0F);
    #1;
    chkb("t5_tie_ready0", req0_ready, 1'b1);
    chkb("t5_tie_ready1", req1_ready, 1'b0);
    step();
    #1;
    chkb("t5_next_ready1", req1_ready, 1'b1);
    chkb("t5_next_ready0", req0_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chkb("t5_r0_id", resp_id, 1'b0);
    chk ("t5_r0_result", resp_result, 32'h0F);
    chkb("t5_r0_err", resp_err, 1'b0);
    step();
    #1;
    chkb("t5_r1_id", resp_id, 1'b1);
    chk ("t5_r1_result", resp_result, 32'hFF);
    step();

    // 6: reset while HOLD is stalled and EXEC is full
    resp_ready = 1'b0;
    set0(1'b1, OP_ADD, 5'd0, 32'd1, 32'd1);
    step();
    req0_valid = 1'b0;
    set1(1'b1, OP_ADD, 5'd0, 32'd2, 32'd2);
    step();
    set0(1'b1, OP_ADD, 5'd0, 32'd9, 32'd1);
    set1(1'b1, OP_ADD, 5'd0, 32'd3, 32'd3);
    #1;
    chkb("t6_pre_valid", resp_valid, 1'b1);
    chkb("t6_pre_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chkb("t6_rst_valid", resp_valid, 1'b0);
    chkb("t6_rst_busy", busy, 1'b0);
    chk ("t6_rst_result", resp_result, 32'h0);
    chkb("t6_rst_ready0", req0_ready, 1'b0);
    chkb("t6_rst_ready1", req1_ready, 1'b0);
    step();
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    chkb("t6_tie_ready0", req0_ready, 1'b1);
    chkb("t6_tie_ready1", req1_ready, 1'b0);
    chkb("t6_post_valid", resp_valid, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chkb("t6_no_stale", resp_valid, 1'b0);
    step();
    #1;
    chkb("t6_resp_valid", resp_valid, 1'b1);
    chkb("t6_resp_id", resp_id, 1'b0);
    chk ("t6_resp_result", resp_result, 32'd10);
    step();
    #1;
    chkb("t6_end_valid", resp_valid, 1'b0);
    chkb("t6_end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
